// File: rtl/seg7_scan_display_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_display_if
//   Digit-write bus from the processor store path into the 7-segment driver.
//   One write per cycle; the driver ignores indices >= NUM_DIGITS.
//
//   wr_en    1                   write strobe
//   wr_idx   $clog2(NUM_DIGITS)  digit index (0 = rightmost)
//   wr_data  5                   glyph code
//
//   master: the writer (processor / testbench)
//   slave : seg7_scan_display
// ---------------------------------------------------------------------------
interface seg7_scan_display_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic                          wr_en;
    logic [$clog2(NUM_DIGITS)-1:0] wr_idx;
    logic [4:0]                    wr_data;

    modport master (output wr_en, output wr_idx, output wr_data);
    modport slave  (input  wr_en, input  wr_idx, input  wr_data);
endinterface

// File: rtl/seg7_scan_display.sv
// ---------------------------------------------------------------------------
// seg7_scan_display
//   Time-multiplexed NUM_DIGITS-digit 7-segment driver. Digit glyphs are
//   written over the wr bus, optionally double-buffered so a whole frame
//   changes at once, and scanned onto shared segment pins with one-hot
//   digit enables. A debounced show input and an optional blink blank the
//   display without losing the stored glyphs.
//
//   clk         in   system clock, rising edge
//   reset       in   asynchronous reset, active low
//   wr          in   digit write bus (slave modport)
//   show        in   raw show/blank level, asynchronous
//   blink_en    in   1: blank on alternate blink periods
//   segments    out  {g,f,e,d,c,b,a}, inverted when ACTIVE_LOW_SEG
//   digit_sel   out  one-hot active-high digit enable, 0 when blanked
//   frame_done  out  1-cycle pulse in the last cycle of the last digit slot
// ---------------------------------------------------------------------------
module seg7_scan_display #(
    parameter int NUM_DIGITS      = 4,
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BLINK_LOG2      = 3,
    parameter bit UPDATE_ON_FRAME = 1'b1,
    parameter bit ACTIVE_LOW_SEG  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    seg7_scan_display_if.slave    wr,
    input  logic                  show,
    input  logic                  blink_en,
    output logic [6:0]            segments,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  frame_done
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FC_W  = BLINK_LOG2 + 1;
    localparam logic [4:0] GLYPH_BLANK = 5'd31;

    // Internal segment pattern is active-high {g,f,e,d,c,b,a}.
    function automatic logic [6:0] glyph_of(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'd0:    seg = 7'h3F;
            5'd1:    seg = 7'h06;
            5'd2:    seg = 7'h5B;
            5'd3:    seg = 7'h4F;
            5'd4:    seg = 7'h66;
            5'd5:    seg = 7'h6D;
            5'd6:    seg = 7'h7D;
            5'd7:    seg = 7'h07;
            5'd8:    seg = 7'h7F;
            5'd9:    seg = 7'h6F;
            5'd10:   seg = 7'h77;
            5'd11:   seg = 7'h7C;
            5'd12:   seg = 7'h39;
            5'd13:   seg = 7'h5E;
            5'd14:   seg = 7'h79;
            5'd15:   seg = 7'h71;
            5'd16:   seg = 7'h76;   // H
            5'd17:   seg = 7'h38;   // L
            5'd18:   seg = 7'h73;   // P
            5'd19:   seg = 7'h3E;   // U
            5'd20:   seg = 7'h50;   // r
            5'd21:   seg = 7'h54;   // n
            5'd22:   seg = 7'h5C;   // o
            5'd23:   seg = 7'h40;   // -
            default: seg = 7'h00;   // 24-31 blank
        endcase
        return seg;
    endfunction

    logic [4:0]            shadow_q [NUM_DIGITS];
    logic [4:0]            shadow_d [NUM_DIGITS];
    logic [4:0]            active_q [NUM_DIGITS];
    logic [4:0]            active_d [NUM_DIGITS];
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [FC_W-1:0]       fc_q, fc_d;
    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic                  stable_q, stable_d;
    logic [DEB_W-1:0]      deb_q, deb_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;

    logic pre_term, last_digit, frame_end, wr_ok, blank;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise an untaken path would hold its old value and infer a latch.
        pre_term   = (pre_q == PRE_W'(SCAN_DIV - 1));
        last_digit = (idx_q == IDX_W'(NUM_DIGITS - 1));
        frame_end  = pre_term && last_digit;
        wr_ok      = wr.wr_en && (int'(wr.wr_idx) < NUM_DIGITS);

        // Scan position: prescaler, digit index, frame counter for blink.
        pre_d = pre_term ? '0 : pre_q + PRE_W'(1);
        idx_d = idx_q;
        if (pre_term) idx_d = last_digit ? '0 : idx_q + IDX_W'(1);
        fc_d  = frame_end ? fc_q + FC_W'(1) : fc_q;

        // Digit storage. shadow_d already holds this cycle's write, so a write
        // landing on the frame_done cycle is part of that frame's copy.
        shadow_d = shadow_q;
        active_d = active_q;
        if (wr_ok) shadow_d[wr.wr_idx] = wr.wr_data;
        if (UPDATE_ON_FRAME) begin
            if (frame_end) active_d = shadow_d;
        end else if (wr_ok) begin
            active_d[wr.wr_idx] = wr.wr_data;
        end

        // Show debounce: count consecutive mismatch cycles, restart on any gap.
        sync1_d  = show;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        deb_d    = '0;
        if (sync2_q != stable_q) begin
            if (deb_q == DEB_W'(DEBOUNCE_CYCLES - 1)) stable_d = ~stable_q;
            else                                      deb_d    = deb_q + DEB_W'(1);
        end

        // Registered pin drive from the current scan position.
        blank = !stable_q || (blink_en && fc_q[BLINK_LOG2]);
        seg_d = '0;
        sel_d = '0;
        if (!blank) begin
            seg_d        = glyph_of(active_q[idx_q]);
            sel_d[idx_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: digit storage is reset as well, so the display starts blank
            // and a reset mid-operation drops any pending shadow writes.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= GLYPH_BLANK;
                active_q[i] <= GLYPH_BLANK;
            end
            idx_q    <= '0;
            pre_q    <= '0;
            fc_q     <= '0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            deb_q    <= '0;
            seg_q    <= '0;
            sel_q    <= '0;
        end else begin
            // NOTE: state uses non-blocking assignment so every flop samples
            // the pre-edge values regardless of statement order.
            shadow_q <= shadow_d;
            active_q <= active_d;
            idx_q    <= idx_d;
            pre_q    <= pre_d;
            fc_q     <= fc_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            deb_q    <= deb_d;
            seg_q    <= seg_d;
            sel_q    <= sel_d;
        end
    end

    assign segments   = ACTIVE_LOW_SEG ? ~seg_q : seg_q;
    assign digit_sel  = sel_q;
    assign frame_done = frame_end;

endmodule
